deserializer: RTL

//   Receive end of the start-framed serial link: recovers WIDTH-bit words (LSB first) from serial_in,

---
 rtl/ser_link_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/deserializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ser_link_pkg.sv
// Shared definitions for the start-framed serial link (serializer and
// deserializer sides).
//   rx_state_t     receiver FSM states
//   SER_WIDTH_DEF  default word width used by both ends of the link
package ser_link_pkg;

  localparam int SER_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug statistics.
//   clk  clock
//   rst  asynchronous active-high reset, clears q
//   inc  count enable, one increment per cycle
//   q    count value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/deserializer.sv
// Receive end of the start-framed serial link. A one-cycle start pulse is
// followed by WIDTH data bits, LSB first; the recovered word is offered on a
// valid/ready port. Early starts abort the frame (frame_err), words completed
// while the previous one is still unread overwrite it (overrun).
//   clk        clock
//   rst        asynchronous active-high reset
//   serial_in  serial data, one bit per cycle
//   start      frame sync, high one cycle before bit 0
//   out_data   recovered word
//   out_valid  word available
//   out_ready  consumer accepts the word
//   frame_err  1-cycle pulse, frame aborted by a start inside a frame
//   overrun    1-cycle pulse, unread word overwritten
//   frame_cnt  completed words, saturating
//   err_cnt    frame_err events, saturating
//
// state | meaning
// IDLE  | waiting for start; serial_in ignored
// RECV  | shifting in bits 0..WIDTH-1
module deserializer
  import ser_link_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  rx_state_t        state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n, frame_err_n, overrun_n;
  logic             frame_inc, err_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sr        <= sr_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    sr_n        = sr;
    data_n      = out_data;
    valid_n     = out_valid;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;

    if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = RECV;
          bit_cnt_n = '0;
        end
      end
      RECV: begin
        if (start) begin
          // The aborting start is also the start of the next frame.
          frame_err_n = 1'b1;
          err_inc     = 1'b1;
          bit_cnt_n   = '0;
          sr_n        = '0;
        end else begin
          sr_n      = {serial_in, sr[WIDTH-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // Load the word on the same edge that samples its last bit so
            // out_valid appears WIDTH+1 cycles after start.
            state_n   = IDLE;
            bit_cnt_n = '0;
            data_n    = sr_n;
            valid_n   = 1'b1;
            overrun_n = out_valid && !out_ready;
            frame_inc = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_inc),
    .q   (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .q   (err_cnt)
  );

endmodule
